collision_handler: RTL
======================

# collision_handler

Frame-synchronous consumer of the monkey collision flags. It sits downstream of the collision detector and upstream of monkey movement, fruit drawing and score display. Per-cycle collision strobes are accumulated over one video frame and committed once per frame at `startOfFrame`. The committed results are:
- a sticky fruit-eaten mask
- a saturating score
- a debounced rope-grab level
- single-cycle wall-hit and level-clear pulses

## Interface
Parameters:
- FRUIT_POINTS, 10, points added per newly eaten fruit
- SCORE_W, 16, score width in bits
- ROPE_FRAMES, 3, consecutive rope-collision frames required to assert onRope (range 1..15)

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse at the start of each frame
- wallCollision  in  1  monkey/wall overlap on the current pixel
- ropeCollision  in  1  monkey/rope overlap on the current pixel
- fruitCollision  in  5  monkey/fruit[i] overlap on the current pixel
- clearFruits  in  1  synchronous pulse that restores all fruits (new level)
- fruitEaten  out  5  sticky mask; bit i = 1 means fruit i is hidden
- score  out  SCORE_W  accumulated score
- onRope  out  1  monkey is holding a rope
- wallHit  out  1  one-cycle pulse: wall collision occurred in the last frame
- levelDone  out  1  one-cycle pulse: the last remaining fruit was eaten

## Operation
- States: IDLE, ACCUM, COMMIT.
  - IDLE: entered at reset; collisions ignored; moves to ACCUM on startOfFrame.
  - ACCUM: collisions ORed into live latches wallSeen, ropeSeen and fruitSeen[4:0]. On startOfFrame, the latches are copied to snapshot registers, the live latches are cleared, and the state moves to COMMIT.
  - COMMIT: one cycle; outputs updated from the snapshot; returns to ACCUM unconditionally.
- Collision on the same cycle as startOfFrame: belongs to the new frame. It is written into the freshly cleared live latch.
- Collision during COMMIT: accumulated into the live latches normally.
- startOfFrame during IDLE→ACCUM transition or during COMMIT: starts/continues the frame only; no extra commit. Back-to-back frames of 1–2 cycles are unsupported.
- Fruit accounting in COMMIT:
  - newFruit = snapFruit & ~fruitEaten
  - fruitEaten |= newFruit
  - score += popcount(newFruit) × FRUIT_POINTS, computed at SCORE_W+1 bits and saturating at 2^SCORE_W − 1
- levelDone pulses in COMMIT when fruitEaten transitions from not-all-ones to all-ones.
- clearFruits: fruitEaten ← 0 on the next edge. Score is unchanged. If it coincides with COMMIT, the clear wins for the mask, while score still adds and levelDone still fires if applicable.
- wallHit pulses in COMMIT iff snapWall = 1.
- Rope (debounce path):
  - 4-bit ropeCnt increments in COMMIT when snapRope = 1, saturating at ROPE_FRAMES. It clears to 0 when snapRope = 0.
  - onRope = 1 while ropeCnt == ROPE_FRAMES; it is updated at the same edge as the count.

## Timing
- All outputs registered.
- Reset values: fruitEaten=0, score=0, onRope=0, wallHit=0, levelDone=0, state=IDLE, all latches, snapshots and ropeCnt = 0.
- Latency: startOfFrame sampled at edge N → COMMIT during cycle N..N+1 → outputs valid after edge N+1, i.e. 2 cycles after the pulse is asserted.
- wallHit and levelDone are high for exactly one cycle (the cycle after the COMMIT edge).
- Reset mid-frame discards all accumulated collisions. The first commit occurs at the second startOfFrame after reset release: the first pulse only leaves IDLE.
- No handshake; downstream consumers sample the level outputs any time and the pulses on the frame boundary.

## Configuration
- ROPE_DEBOUNCE_EN defined: rope debounce counter present as described; onRope requires ROPE_FRAMES consecutive frames.
- ROPE_DEBOUNCE_EN undefined: no counter; in each COMMIT onRope ← snapRope. The ROPE_FRAMES parameter is ignored.

## Test plan
- Reset, 2 startOfFrame pulses, fruitCollision=5'b00100 for 3 cycles mid-frame, then startOfFrame → fruitEaten=5'b00100 and score=10 two cycles later; further fruit-2 hits in later frames leave score=10.
- fruitCollision 5'b01011 in one frame, 5'b10100 in the next → score 30, then 50; levelDone pulses one cycle after the second commit; clearFruits → fruitEaten=0, score stays 50.
- SCORE_W=6 with repeated full-fruit frames plus clearFruits each frame → score saturates at 63 and never wraps.
- ropeCollision in frames 1,2,3 (ROPE_DEBOUNCE_EN, ROPE_FRAMES=3) → onRope=1 after the 3rd commit; frame without rope → onRope=0 at the next commit; pattern 1,1,0,1 never asserts onRope.
- wallCollision asserted on the same cycle as startOfFrame only → no wallHit at that commit; wallHit pulses one cycle at the following commit.
- resetN asserted mid-frame after fruit and wall hits → all outputs 0 immediately; no wallHit/score change at the next startOfFrame.

Source files
------------

// File: rtl/collision_handler.sv
// collision_handler: accumulates per-pixel monkey collision strobes over a frame and commits them at startOfFrame.
// Build macro ROPE_DEBOUNCE_EN adds the multi-frame rope debounce counter; without it onRope follows the last frame.
module collision_handler #(
    parameter int FRUIT_POINTS = 10,
    parameter int SCORE_W      = 16,
    parameter int ROPE_FRAMES  = 3
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               wallCollision,
    input  logic               ropeCollision,
    input  logic [4:0]         fruitCollision,
    input  logic               clearFruits,
    output logic [4:0]         fruitEaten,
    output logic [SCORE_W-1:0] score,
    output logic               onRope,
    output logic               wallHit,
    output logic               levelDone
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [4:0]       ALL_FRUITS = 5'b11111;
    localparam logic [SCORE_W:0] SCORE_MAX  = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0] POINTS     = (SCORE_W+1)'(FRUIT_POINTS);

    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    state_t       state_r;
    logic         wall_seen_r, rope_seen_r;
    logic [4:0]   fruit_seen_r;
    logic         snap_wall_r, snap_rope_r;
    logic [4:0]   snap_fruit_r;

    logic [4:0]         new_fruit_s;
    logic [4:0]         eaten_next_s;
    logic [SCORE_W:0]   score_sum_s;
    logic [SCORE_W-1:0] score_next_s;

    // Fruit accounting for the commit cycle; the sum carries one extra bit so saturation is detectable
    always_comb begin
        new_fruit_s  = snap_fruit_r & ~fruitEaten;
        eaten_next_s = fruitEaten | new_fruit_s;
        score_sum_s  = {1'b0, score} + POINTS * (SCORE_W+1)'(popcount5(new_fruit_s));
        if (score_sum_s > SCORE_MAX) begin
            score_next_s = SCORE_MAX[SCORE_W-1:0];
        end else begin
            score_next_s = score_sum_s[SCORE_W-1:0];
        end
    end

`ifdef ROPE_DEBOUNCE_EN
    localparam logic [3:0] ROPE_MAX = 4'(ROPE_FRAMES);
    logic [3:0] rope_cnt_r;
    logic [3:0] rope_cnt_next_s;

    // Consecutive-frame rope counter: any rope-free frame restarts the debounce
    always_comb begin
        if (!snap_rope_r) begin
            rope_cnt_next_s = 4'd0;
        end else if (rope_cnt_r >= ROPE_MAX) begin
            rope_cnt_next_s = ROPE_MAX;
        end else begin
            rope_cnt_next_s = rope_cnt_r + 4'd1;
        end
    end
`endif

    // Frame FSM: live latches, per-frame snapshot and all registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r      <= IDLE;
            wall_seen_r  <= 1'b0;
            rope_seen_r  <= 1'b0;
            fruit_seen_r <= 5'd0;
            snap_wall_r  <= 1'b0;
            snap_rope_r  <= 1'b0;
            snap_fruit_r <= 5'd0;
            fruitEaten   <= 5'd0;
            score        <= '0;
            onRope       <= 1'b0;
            wallHit      <= 1'b0;
            levelDone    <= 1'b0;
`ifdef ROPE_DEBOUNCE_EN
            rope_cnt_r   <= 4'd0;
`endif
        end else begin
            wallHit   <= 1'b0;
            levelDone <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A strobe coincident with the first pulse already belongs to the new frame
                    if (startOfFrame) begin
                        state_r      <= ACCUM;
                        wall_seen_r  <= wallCollision;
                        rope_seen_r  <= ropeCollision;
                        fruit_seen_r <= fruitCollision;
                    end
                end
                ACCUM: begin
                    if (startOfFrame) begin
                        state_r      <= COMMIT;
                        snap_wall_r  <= wall_seen_r;
                        snap_rope_r  <= rope_seen_r;
                        snap_fruit_r <= fruit_seen_r;
                        wall_seen_r  <= wallCollision;
                        rope_seen_r  <= ropeCollision;
                        fruit_seen_r <= fruitCollision;
                    end else begin
                        wall_seen_r  <= wall_seen_r | wallCollision;
                        rope_seen_r  <= rope_seen_r | ropeCollision;
                        fruit_seen_r <= fruit_seen_r | fruitCollision;
                    end
                end
                COMMIT: begin
                    state_r      <= ACCUM;
                    wall_seen_r  <= wall_seen_r | wallCollision;
                    rope_seen_r  <= rope_seen_r | ropeCollision;
                    fruit_seen_r <= fruit_seen_r | fruitCollision;
                    wallHit      <= snap_wall_r;
                    levelDone    <= (fruitEaten != ALL_FRUITS) && (eaten_next_s == ALL_FRUITS);
                    fruitEaten   <= eaten_next_s;
                    score        <= score_next_s;
`ifdef ROPE_DEBOUNCE_EN
                    rope_cnt_r   <= rope_cnt_next_s;
                    onRope       <= (rope_cnt_next_s == ROPE_MAX);
`else
                    onRope       <= snap_rope_r;
`endif
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            // A new level restores every fruit, overriding any mask update in the same cycle
            if (clearFruits) begin
                fruitEaten <= 5'd0;
            end
        end
    end
endmodule
